fork_launch: RTL and testbench

Receiving end of the fork path. Takes the per-core fork contexts produced by the fork stage and brings each target core up: it latches the start PC and data pointer, pulses a one-cycle start strobe, and tracks the core until it halts. It owns the authoritative core-enable vector, which feeds back into the fork stage's `core_ens_in`. A core's enable bit clears only after the core has halted and drained, and only then can the core be forked again.

---
 rtl/fork_launch.sv | 133 +++++++++++++
 tb/tb_fork_launch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_launch.sv
// Fork receive stage: accepts per-core fork contexts, pulses start, and tracks each core to halt.
// Optional statistics counters are compiled in with `define FORK_LAUNCH_STATS_EN.
module fork_launch #(
  parameter int NCORES = 4,
  parameter int CW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES*33-1:0] fork_cxt_in,
  input  logic [NCORES-1:0]    halt,
  output logic [NCORES-1:0]    core_ens,
  output logic [NCORES-1:0]    fork_ack,
  output logic [NCORES-1:0]    start,
  output logic [NCORES*16-1:0] start_pc,
  output logic [NCORES*16-1:0] start_ptr,
  output logic [CW-1:0]        active_cnt,
  output logic                 all_idle
`ifdef FORK_LAUNCH_STATS_EN
  ,
  output logic [15:0]          launch_cnt,
  output logic [15:0]          halt_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r     [NCORES];
  state_t            state_nxt_s [NCORES];
  logic [NCORES-1:0] accept_s;
  logic [NCORES-1:0] halt_evt_s;
  logic [CW-1:0]     cnt_nxt_s;

  // Next-state decode per core; a valid slot outside IDLE is a stale context and is dropped.
  always_comb begin
    cnt_nxt_s = {CW{1'b0}};
    for (int i = 0; i < NCORES; i++) begin
      state_nxt_s[i] = state_r[i];
      accept_s[i]    = 1'b0;
      halt_evt_s[i]  = 1'b0;
      case (state_r[i])
        IDLE: begin
          if (fork_cxt_in[i*33+32]) begin
            accept_s[i]    = 1'b1;
            state_nxt_s[i] = LOAD;
          end else begin
            state_nxt_s[i] = IDLE;
          end
        end
        LOAD: state_nxt_s[i] = RUN;
        RUN: begin
          if (halt[i]) begin
            halt_evt_s[i]  = 1'b1;
            state_nxt_s[i] = DONE;
          end else begin
            state_nxt_s[i] = RUN;
          end
        end
        DONE:    state_nxt_s[i] = IDLE;
        default: state_nxt_s[i] = IDLE;
      endcase
      if (state_nxt_s[i] != IDLE) begin
        cnt_nxt_s = cnt_nxt_s + CW'(1);
      end else begin
        cnt_nxt_s = cnt_nxt_s;
      end
    end
  end

  // Core state, enables, strobes, latched contexts and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCORES; i++) begin
        state_r[i] <= IDLE;
      end
      core_ens   <= {NCORES{1'b0}};
      fork_ack   <= {NCORES{1'b0}};
      start      <= {NCORES{1'b0}};
      start_pc   <= {(NCORES*16){1'b0}};
      start_ptr  <= {(NCORES*16){1'b0}};
      active_cnt <= {CW{1'b0}};
      all_idle   <= 1'b1;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        state_r[i]  <= state_nxt_s[i];
        core_ens[i] <= (state_nxt_s[i] != IDLE);
        fork_ack[i] <= accept_s[i];
        start[i]    <= accept_s[i];
        if (accept_s[i]) begin
          start_pc[i*16 +: 16]  <= fork_cxt_in[i*33 +: 16];
          start_ptr[i*16 +: 16] <= fork_cxt_in[i*33+16 +: 16];
        end
      end
      active_cnt <= cnt_nxt_s;
      all_idle   <= (cnt_nxt_s == {CW{1'b0}});
    end
  end

`ifdef FORK_LAUNCH_STATS_EN
  logic [16:0] acc_pop_s;
  logic [16:0] halt_pop_s;
  logic [16:0] launch_sum_s;
  logic [16:0] halt_sum_s;

  // Per-cycle event counts, added into the saturating statistics counters.
  always_comb begin
    acc_pop_s  = 17'd0;
    halt_pop_s = 17'd0;
    for (int i = 0; i < NCORES; i++) begin
      acc_pop_s  = acc_pop_s + 17'(accept_s[i]);
      halt_pop_s = halt_pop_s + 17'(halt_evt_s[i]);
    end
    launch_sum_s = {1'b0, launch_cnt} + acc_pop_s;
    halt_sum_s   = {1'b0, halt_cnt} + halt_pop_s;
  end

  // Statistics registers clamp at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch_cnt <= 16'h0000;
      halt_cnt   <= 16'h0000;
    end else begin
      launch_cnt <= launch_sum_s[16] ? 16'hFFFF : launch_sum_s[15:0];
      halt_cnt   <= halt_sum_s[16] ? 16'hFFFF : halt_sum_s[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fork_launch.sv
// Directed bench for fork_launch: a timeline model of each core's lifetime is
// compared every cycle, plus literal checks at the key points of each scenario.
module tb_fork_launch;
  localparam int NC = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic [NC*33-1:0] fork_cxt_in;
  logic [NC-1:0]   halt;
  logic [NC-1:0]   core_ens;
  logic [NC-1:0]   fork_ack;
  logic [NC-1:0]   start;
  logic [NC*16-1:0] start_pc;
  logic [NC*16-1:0] start_ptr;
  logic [CW-1:0]   active_cnt;
  logic            all_idle;
`ifdef FORK_LAUNCH_STATS_EN
  logic [15:0]     launch_cnt;
  logic [15:0]     halt_cnt;
`endif

  fork_launch #(.NCORES(NC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .fork_cxt_in(fork_cxt_in), .halt(halt),
    .core_ens(core_ens), .fork_ack(fork_ack), .start(start),
    .start_pc(start_pc), .start_ptr(start_ptr),
    .active_cnt(active_cnt), .all_idle(all_idle)
`ifdef FORK_LAUNCH_STATS_EN
    , .launch_cnt(launch_cnt), .halt_cnt(halt_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each core is described by the edge it was accepted at and the edge its halt was taken.
  int          edge_no;
  int          acc_e [NC];
  int          hlt_e [NC];
  logic [15:0] m_pc  [NC];
  logic [15:0] m_ptr [NC];
  int          m_launch, m_halt;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        edge_no = 0; m_launch = 0; m_halt = 0;
        for (int i = 0; i < NC; i++) begin
          acc_e[i] = -1; hlt_e[i] = -1; m_pc[i] = 16'h0; m_ptr[i] = 16'h0;
        end
      end else begin
        edge_no = edge_no + 1;
        for (int i = 0; i < NC; i++) begin
          if (acc_e[i] < 0) begin
            if (fork_cxt_in[i*33+32]) begin
              acc_e[i] = edge_no;
              m_pc[i]  = fork_cxt_in[i*33 +: 16];
              m_ptr[i] = fork_cxt_in[i*33+16 +: 16];
              m_launch++;
            end
          end else if (hlt_e[i] < 0) begin
            // halt only counts from the second edge after accept onward
            if (edge_no >= acc_e[i] + 2 && halt[i]) begin
              hlt_e[i] = edge_no;
              m_halt++;
            end
          end else begin
            acc_e[i] = -1; hlt_e[i] = -1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    logic [NC-1:0]    e_en, e_st;
    logic [NC*16-1:0] e_pc, e_ptr;
    int               e_cnt;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_cnt = 0;
        for (int i = 0; i < NC; i++) begin
          e_en[i] = (acc_e[i] >= 0);
          e_st[i] = (acc_e[i] >= 0) && (acc_e[i] == edge_no);
          e_pc[i*16 +: 16]  = m_pc[i];
          e_ptr[i*16 +: 16] = m_ptr[i];
          if (acc_e[i] >= 0) e_cnt++;
        end
        chk("m_core_ens", 64'(core_ens), 64'(e_en));
        chk("m_start", 64'(start), 64'(e_st));
        chk("m_fork_ack", 64'(fork_ack), 64'(e_st));
        chk("m_start_pc", 64'(start_pc), 64'(e_pc));
        chk("m_start_ptr", 64'(start_ptr), 64'(e_ptr));
        chk("m_active_cnt", 64'(active_cnt), 64'(e_cnt));
        chk("m_all_idle", 64'(all_idle), 64'(e_cnt == 0));
`ifdef FORK_LAUNCH_STATS_EN
        chk("m_launch_cnt", 64'(launch_cnt), 64'((m_launch > 65535) ? 65535 : m_launch));
        chk("m_halt_cnt", 64'(halt_cnt), 64'((m_halt > 65535) ? 65535 : m_halt));
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic v, input logic [15:0] ptr, input logic [15:0] pc);
    fork_cxt_in[i*33 +: 33] = {v, ptr, pc};
  endtask

  initial begin
    int pulses;
    logic [15:0] l0, h0;
    rst = 1'b1;
    fork_cxt_in = '0;
    halt = '0;
    tick(); tick();
    chk("rst_core_ens", 64'(core_ens), 64'h0);
    chk("rst_all_idle", 64'(all_idle), 64'h1);
    chk("rst_active_cnt", 64'(active_cnt), 64'h0);
    rst = 1'b0;
    tick();

    // Single fork on core 0
    set_slot(0, 1'b1, 16'h0040, 16'h0123);
    tick();
    set_slot(0, 1'b0, 16'h0, 16'h0);
    chk("t1_core_ens", 64'(core_ens), 64'h1);
    chk("t1_start_pc0", 64'(start_pc[15:0]), 64'h0123);
    chk("t1_start_ptr0", 64'(start_ptr[15:0]), 64'h0040);
    chk("t1_start", 64'(start), 64'h1);
    chk("t1_fork_ack", 64'(fork_ack), 64'h1);
    chk("t1_active_cnt", 64'(active_cnt), 64'h1);
    chk("t1_all_idle", 64'(all_idle), 64'h0);
    tick();
    chk("t1_start_off", 64'(start), 64'h0);

    // Halt after 5 RUN cycles, with slot 0 held valid for re-fork
    repeat (4) tick();
    halt[0] = 1'b1;
    set_slot(0, 1'b1, 16'h0050, 16'h0200);
    tick();
    halt[0] = 1'b0;
    chk("t2_done_en", 64'(core_ens[0]), 64'h1);
    tick();
    chk("t2_fall_en", 64'(core_ens[0]), 64'h0);
    tick();
    set_slot(0, 1'b0, 16'h0, 16'h0);
    chk("t2_reaccept_en", 64'(core_ens[0]), 64'h1);
    chk("t2_restart", 64'(start[0]), 64'h1);
    chk("t2_restart_pc", 64'(start_pc[15:0]), 64'h0200);

    // Stale valid on slot 1 with a changing pc
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      set_slot(1, 1'b1, 16'h0777, 16'h1000 + 16'(k));
      tick();
      if (start[1]) pulses++;
    end
    set_slot(1, 1'b0, 16'h0, 16'h0);
    chk("t3_one_accept", 64'(pulses), 64'h1);
    chk("t3_pc_held", 64'(start_pc[31:16]), 64'h1000);
    halt[1] = 1'b1;
    tick();
    halt[1] = 1'b0;
    tick();
    chk("t3_core1_off", 64'(core_ens), 64'h1);

    // Core 0 halts while cores 2 and 3 accept
    chk("t4_cnt_before", 64'(active_cnt), 64'h1);
`ifdef FORK_LAUNCH_STATS_EN
    l0 = launch_cnt; h0 = halt_cnt;
`else
    l0 = 16'h0; h0 = 16'h0;
`endif
    halt[0] = 1'b1;
    set_slot(2, 1'b1, 16'h2222, 16'h0A02);
    set_slot(3, 1'b1, 16'h3333, 16'h0A03);
    tick();
    halt[0] = 1'b0;
    set_slot(2, 1'b0, 16'h0, 16'h0);
    set_slot(3, 1'b0, 16'h0, 16'h0);
    chk("t4_cnt_3", 64'(active_cnt), 64'h3);
`ifdef FORK_LAUNCH_STATS_EN
    chk("t4_launch_d", 64'(launch_cnt - l0), 64'h2);
    chk("t4_halt_d", 64'(halt_cnt - h0), 64'h1);
`endif
    tick();
    chk("t4_cnt_2", 64'(active_cnt), 64'h2);

    // Halts ignored in IDLE and LOAD on core 1
    halt[1] = 1'b1;
    tick(); tick();
    chk("t5_idle_halt", 64'(core_ens[1]), 64'h0);
    set_slot(1, 1'b1, 16'h0BBB, 16'h3000);
    tick();
    set_slot(1, 1'b0, 16'h0, 16'h0);
    chk("t5_accept", 64'(start[1]), 64'h1);
    tick();
    halt[1] = 1'b0;
    chk("t5_load_halt", 64'(core_ens[1]), 64'h1);
    tick();
    chk("t5_in_run", 64'(core_ens[1]), 64'h1);

    // Bring core 0 back up so all four run, then reset between edges
    set_slot(0, 1'b1, 16'h0060, 16'h0400);
    tick();
    set_slot(0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    chk("t6_all_run", 64'(core_ens), 64'hF);
    chk("t6_cnt4", 64'(active_cnt), 64'h4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_en", 64'(core_ens), 64'h0);
    chk("t6_rst_idle", 64'(all_idle), 64'h1);
    chk("t6_rst_cnt", 64'(active_cnt), 64'h0);
`ifdef FORK_LAUNCH_STATS_EN
    chk("t6_rst_launch", 64'(launch_cnt), 64'h0);
    chk("t6_rst_halt", 64'(halt_cnt), 64'h0);
`endif
    #1 rst = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
